// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with one-word-per-beat line fill.
module icache #(
    parameter int unsigned INDEX_WIDTH  = 4,
    parameter int unsigned OFFSET_WIDTH = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        icache_query_en,
    input  logic [31:0] icache_query_pc,
    output logic        icache_data_en,
    output logic [31:0] icache_data,
    output logic        mem_query_en,
    output logic [31:0] mem_query_addr,
    input  logic        mem_data_en,
    input  logic [31:0] mem_data
);

    localparam int unsigned LINES = 1 << INDEX_WIDTH;
    localparam int unsigned WORDS = 1 << OFFSET_WIDTH;
    localparam int unsigned LOW   = OFFSET_WIDTH + 2;
    localparam int unsigned TAG_W = 32 - INDEX_WIDTH - LOW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESPOND
    } state_e;

    state_e                    state_q, state_d;
    logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
    logic [31:2]               pc_q, pc_d;
    logic [LINES-1:0]          valid_q, valid_d;
    logic                      data_en_q, data_en_d;
    logic [31:0]               data_q, data_d;
    logic                      mq_en_q, mq_en_d;
    logic [31:0]               mq_addr_q, mq_addr_d;
    logic                      data_we;
    logic                      tag_we;

    logic [TAG_W-1:0]          tag_mem  [LINES];
    logic [31:0]               data_mem [LINES][WORDS];

    logic [OFFSET_WIDTH-1:0]   q_word;
    logic [INDEX_WIDTH-1:0]    q_index;
    logic [TAG_W-1:0]          q_tag;
    logic [OFFSET_WIDTH-1:0]   f_word;
    logic [INDEX_WIDTH-1:0]    f_index;
    logic [TAG_W-1:0]          f_tag;
    logic                      unused_pc_lsb;

    assign q_word        = icache_query_pc[LOW-1:2];
    assign q_index       = icache_query_pc[LOW+INDEX_WIDTH-1:LOW];
    assign q_tag         = icache_query_pc[31:LOW+INDEX_WIDTH];
    assign f_word        = pc_q[LOW-1:2];
    assign f_index       = pc_q[LOW+INDEX_WIDTH-1:LOW];
    assign f_tag         = pc_q[31:LOW+INDEX_WIDTH];
    assign unused_pc_lsb = ^icache_query_pc[1:0];

    assign icache_data_en = data_en_q;
    assign icache_data    = data_q;
    assign mem_query_en   = mq_en_q;
    assign mem_query_addr = mq_addr_q;

    // Next-state logic: hit lookup, miss launch, beat capture and response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        data_en_d = 1'b0;
        data_d    = data_q;
        mq_en_d   = mq_en_q;
        mq_addr_d = mq_addr_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (icache_query_en) begin
                    if (valid_q[q_index] && (tag_mem[q_index] == q_tag)) begin
                        data_en_d = 1'b1;
                        data_d    = data_mem[q_index][q_word];
                    end else begin
                        pc_d             = icache_query_pc[31:2];
                        mq_en_d          = 1'b1;
                        mq_addr_d        = {icache_query_pc[31:LOW], LOW'(0)};
                        valid_d[q_index] = 1'b0;
                        cnt_d            = '0;
                        state_d          = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (mem_data_en) begin
                    data_we = 1'b1;
                    cnt_d   = OFFSET_WIDTH'(cnt_q + 1'b1);
                    if (cnt_q == OFFSET_WIDTH'(WORDS - 1)) begin
                        // Last beat: install the line and answer in the same edge.
                        tag_we           = 1'b1;
                        valid_d[f_index] = 1'b1;
                        mq_en_d          = 1'b0;
                        data_en_d        = 1'b1;
                        data_d           = (f_word == cnt_q) ? mem_data
                                                             : data_mem[f_index][f_word];
                        state_d          = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            valid_q   <= '0;
            data_en_q <= 1'b0;
            data_q    <= '0;
            mq_en_q   <= 1'b0;
            mq_addr_q <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            data_en_q <= data_en_d;
            data_q    <= data_d;
            mq_en_q   <= mq_en_d;
            mq_addr_q <= mq_addr_d;
        end
    end

    // Tag and data storage; contents are qualified by valid_q so no reset needed.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (data_we) begin
                data_mem[f_index][cnt_q] <= mem_data;
            end
            if (tag_we) begin
                tag_mem[f_index] <= f_tag;
            end
        end
    end

endmodule
